// File: rtl/i2c_master.sv
`timescale 1ns/100ps
`default_nettype none
// ============================================================================
// Module   : i2c_master
// Purpose  : Fixed single-byte I2C write issued once after reset:
//            START, {SLAVE_ADDR,W}, ACK, DATA_BYTE, ACK, STOP, then idle high.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_master #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter logic [7:0] DATA_BYTE  = 8'hA5,
  parameter int         CLK_DIV    = 4
) (
  input  logic iw_clk,
  input  logic iw_reset,
  inout  wire  io_i2c_scl,
  inout  wire  io_i2c_sda
);

  localparam int         Q         = CLK_DIV / 4;
  localparam int         QW        = (Q > 1) ? $clog2(Q) : 1;
  localparam logic [QW-1:0] Q_LAST = QW'(Q - 1);
  localparam logic [7:0] ADDR_BYTE = {SLAVE_ADDR, 1'b0};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    ADDR  = 3'd2,
    ACK1  = 3'd3,
    DATA  = 3'd4,
    ACK2  = 3'd5,
    STOP  = 3'd6,
    DONE  = 3'd7
  } state_t;

  state_t          state, state_nx;
  logic [1:0]      quarter, quarter_nx;
  logic [QW-1:0]   qcnt, qcnt_nx;
  logic [2:0]      bit_cnt, bit_cnt_nx;
  logic            nack, nack_nx;
  logic            scl_q, sda_q, sda_oe;
  logic            scl_nx, sda_nx, oe_nx;
  logic            q_end;

  // Both pins are driven from registers; SDA is released only in ACK slots.
  assign io_i2c_scl = scl_q;
  assign io_i2c_sda = sda_oe ? sda_q : 1'bz;

  assign q_end = (qcnt == Q_LAST);

  // Next bus position (slot, quarter, bit), ACK sampling and pin levels for it.
  always_comb begin
    state_nx   = state;
    quarter_nx = quarter;
    qcnt_nx    = qcnt;
    bit_cnt_nx = bit_cnt;
    nack_nx    = nack;
    scl_nx     = 1'b1;
    sda_nx     = 1'b1;
    oe_nx      = 1'b1;

    if (state != DONE) begin
      if (!q_end) begin
        qcnt_nx = qcnt + 1'b1;
      end else begin
        qcnt_nx = '0;
        if (quarter != 2'd3) begin
          quarter_nx = quarter + 2'd1;
        end else begin
          quarter_nx = 2'd0;
          case (state)
            IDLE:  state_nx = START;
            START: begin
              state_nx   = ADDR;
              bit_cnt_nx = 3'd7;
            end
            ADDR: begin
              if (bit_cnt == 3'd0) state_nx = ACK1;
              else                 bit_cnt_nx = bit_cnt - 3'd1;
            end
            ACK1: begin
              // An unanswered address aborts straight to STOP.
              if (nack) state_nx = STOP;
              else begin
                state_nx   = DATA;
                bit_cnt_nx = 3'd7;
              end
            end
            DATA: begin
              if (bit_cnt == 3'd0) state_nx = ACK2;
              else                 bit_cnt_nx = bit_cnt - 3'd1;
            end
            ACK2:    state_nx = STOP;
            STOP:    state_nx = DONE;
            default: state_nx = DONE;
          endcase
        end
      end

      // Only a solid 0 counts as ACK; 1, z or x are all treated as NACK.
      if ((state == ACK1 || state == ACK2) && quarter == 2'd2 && q_end) begin
        case (io_i2c_sda)
          1'b0:    nack_nx = nack;
          default: nack_nx = 1'b1;
        endcase
      end
    end

    case (state_nx)
      START: sda_nx = (quarter_nx < 2'd2);
      ADDR: begin
        scl_nx = quarter_nx[1];
        sda_nx = ADDR_BYTE[bit_cnt_nx];
      end
      DATA: begin
        scl_nx = quarter_nx[1];
        sda_nx = DATA_BYTE[bit_cnt_nx];
      end
      ACK1, ACK2: begin
        scl_nx = quarter_nx[1];
        oe_nx  = 1'b0;
      end
      STOP: begin
        scl_nx = quarter_nx[1];
        sda_nx = (quarter_nx == 2'd3);
      end
      default: begin
        scl_nx = 1'b1;
        sda_nx = 1'b1;
      end
    endcase
  end

  // Sequencer state and registered pin levels; reset lands on the first IDLE cycle.
  always_ff @(posedge iw_clk or posedge iw_reset) begin
    if (iw_reset) begin
      state   <= IDLE;
      quarter <= 2'd0;
      qcnt    <= '0;
      bit_cnt <= 3'd0;
      nack    <= 1'b0;
      scl_q   <= 1'b1;
      sda_q   <= 1'b1;
      sda_oe  <= 1'b1;
    end else begin
      state   <= state_nx;
      quarter <= quarter_nx;
      qcnt    <= qcnt_nx;
      bit_cnt <= bit_cnt_nx;
      nack    <= nack_nx;
      scl_q   <= scl_nx;
      sda_q   <= sda_nx;
      sda_oe  <= oe_nx;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_master.sv
`timescale 1ns/100ps
`default_nettype none
// ============================================================================
// Module   : tb_i2c_master
// Purpose  : Randomized self-checking bench for i2c_master against a slot-list
//            model of the bus waveform (CLK_DIV 4 and 8 instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_master;

  localparam int K_IDLE  = 0;
  localparam int K_START = 1;
  localparam int K_ADDR  = 2;
  localparam int K_ACK1  = 3;
  localparam int K_DATA  = 4;
  localparam int K_ACK2  = 5;
  localparam int K_STOP  = 6;
  localparam int K_DONE  = 7;

  localparam logic [7:0] EXP_ADDR = 8'hA0;
  localparam logic [7:0] EXP_DATA = 8'hA5;

  logic clk = 1'b0;
  logic rst;
  logic sel;
  logic slv_en;
  logic slv_val;
  wire  scl4, sda4, scl8, sda8;
  logic scl_o, sda_o, nack_o;

  int errors = 0;
  int checks = 0;

  int          kind_q[$];
  logic        bit_q[$];

  // 2 ns system clock.
  always #1 clk = ~clk;

  // Bench-side slave: drives the ACK level (1 models the pull-up when absent).
  assign sda4 = (slv_en && !sel) ? slv_val : 1'bz;
  assign sda8 = (slv_en &&  sel) ? slv_val : 1'bz;

  i2c_master #(.SLAVE_ADDR(7'h50), .DATA_BYTE(8'hA5), .CLK_DIV(4)) dut4 (
    .iw_clk(clk), .iw_reset(rst), .io_i2c_scl(scl4), .io_i2c_sda(sda4)
  );

  i2c_master #(.SLAVE_ADDR(7'h50), .DATA_BYTE(8'hA5), .CLK_DIV(8)) dut8 (
    .iw_clk(clk), .iw_reset(rst), .io_i2c_scl(scl8), .io_i2c_sda(sda8)
  );

  assign scl_o  = sel ? scl8 : scl4;
  assign sda_o  = sel ? sda8 : sda4;
  assign nack_o = sel ? dut8.nack : dut4.nack;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Slot list of the whole transaction for the given slave responses.
  task automatic build(input bit ack1, input bit ack2);
    logic [7:0] a, d;
    a = EXP_ADDR;
    d = EXP_DATA;
    kind_q = {};
    bit_q  = {};
    kind_q.push_back(K_IDLE);  bit_q.push_back(1'b1);
    kind_q.push_back(K_START); bit_q.push_back(1'b1);
    for (int i = 7; i >= 0; i--) begin
      kind_q.push_back(K_ADDR); bit_q.push_back(a[i]);
    end
    kind_q.push_back(K_ACK1); bit_q.push_back(1'b1);
    if (ack1) begin
      for (int i = 7; i >= 0; i--) begin
        kind_q.push_back(K_DATA); bit_q.push_back(d[i]);
      end
      kind_q.push_back(K_ACK2); bit_q.push_back(1'b1);
    end
    kind_q.push_back(K_STOP); bit_q.push_back(1'b1);
    if (ack2) begin end
  endtask

  // One reset + transaction; abort_at >= 0 reasserts reset at that cycle.
  task automatic run(input bit use8, input bit ack1, input bit ack2, input int abort_at);
    int q, total, slot, qtr, kind;
    logic bv, exp_scl, exp_sda;
    logic [7:0] abyte, dbyte;
    q = use8 ? 2 : 1;
    abyte = '0;
    dbyte = '0;
    sel = use8;
    slv_en = 1'b0;
    slv_val = 1'b1;
    build(ack1, ack2);
    total = 4 * q * kind_q.size();

    @(negedge clk);
    #0.3 rst = 1'b1;
    #0.1;
    chk("rst_scl", 32'(scl_o), 32'd1);
    chk("rst_sda", 32'(sda_o), 32'd1);
    repeat (3) @(negedge clk);
    chk("rst_nack", 32'(nack_o), 32'd0);
    rst = 1'b0;

    for (int p = 0; p <= total + 4 * q; p++) begin
      if (p > 0) @(negedge clk);
      slot = p / (4 * q);
      qtr  = (p % (4 * q)) / q;
      if (slot < kind_q.size()) begin
        kind = kind_q[slot];
        bv   = bit_q[slot];
      end else begin
        kind = K_DONE;
        bv   = 1'b1;
      end
      exp_scl = 1'b1;
      exp_sda = 1'b1;
      case (kind)
        K_START: exp_sda = (qtr < 2);
        K_ADDR, K_DATA: begin exp_scl = (qtr >= 2); exp_sda = bv; end
        K_ACK1, K_ACK2: exp_scl = (qtr >= 2);
        K_STOP: begin exp_scl = (qtr >= 2); exp_sda = (qtr == 3); end
        default: ;
      endcase
      chk($sformatf("scl p%0d", p), 32'(scl_o), 32'(exp_scl));
      if (kind != K_ACK1 && kind != K_ACK2)
        chk($sformatf("sda p%0d", p), 32'(sda_o), 32'(exp_sda));
      // Capture what a slave would read just after each SCL rise.
      if (qtr == 2 && (p % q) == 0) begin
        if (kind == K_ADDR) abyte = {abyte[6:0], sda_o};
        if (kind == K_DATA) dbyte = {dbyte[6:0], sda_o};
      end
      if (p == abort_at) begin
        rst = 1'b1;
        slv_en = 1'b0;
        #0.1;
        chk("abort_scl", 32'(scl_o), 32'd1);
        chk("abort_sda", 32'(sda_o), 32'd1);
        chk("abort_nack", 32'(nack_o), 32'd0);
        return;
      end
      slv_en  = (kind == K_ACK1 || kind == K_ACK2) && (qtr <= 2);
      slv_val = (kind == K_ACK1) ? ~ack1 : ~ack2;
    end
    slv_en = 1'b0;
    chk("addr_byte", 32'(abyte), 32'(EXP_ADDR));
    if (ack1) chk("data_byte", 32'(dbyte), 32'(EXP_DATA));
    chk("nack_flag", 32'(nack_o), 32'(!(ack1 && ack2)));
  endtask

  initial begin
    bit u8, a1, a2;
    int ab;
    rst = 1'b1;
    sel = 1'b0;
    slv_en = 1'b0;
    slv_val = 1'b1;
    run(1'b0, 1'b1, 1'b1, -1);   // full write, both ACKed
    run(1'b0, 1'b0, 1'b0, -1);   // no slave on the bus
    run(1'b0, 1'b1, 1'b0, -1);   // data byte NACKed
    run(1'b0, 1'b1, 1'b1, 50);   // reset in the middle of DATA
    run(1'b0, 1'b1, 1'b1, -1);   // clean restart afterwards
    run(1'b1, 1'b1, 1'b1, -1);   // CLK_DIV = 8
    run(1'b1, 1'b0, 1'b0, -1);
    for (int n = 0; n < 8; n++) begin
      u8 = 1'($urandom % 2);
      a1 = 1'($urandom % 2);
      a2 = 1'($urandom % 2);
      ab = ($urandom % 4 == 0) ? int'($urandom_range(1, 60)) : -1;
      run(u8, a1, a2, ab);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/i2c_master.md
# i2c_master

Self-contained I2C bus master that runs one fixed write transaction after reset: START, 7-bit slave address with write bit, ACK check, one data byte, ACK check, STOP. It has no host-side data port; the address and payload are build-time parameters. It sits at the chip boundary and drives the board-level SCL/SDA pins, e.g. to initialise a single peripheral register at power-up.

## Interface
- SLAVE_ADDR, 7'h50: 7-bit target address; sent MSB first, followed by R/W=0.
- DATA_BYTE, 8'hA5: payload byte; sent MSB first.
- CLK_DIV, 4: iw_clk cycles per SCL period. Must be a multiple of 4 and ≥4. Q = CLK_DIV/4 cycles per quarter-phase.
- iw_clk  input  1  system clock. All state changes on the rising edge.
- iw_reset  input  1  asynchronous, active-high reset.
- io_i2c_scl  inout  1  I2C clock. Driven push-pull by the master; no clock stretching.
- io_i2c_sda  inout  1  I2C data. Driven push-pull except during ACK slots, when it is released to 'z'.

## Operation
- States, in order: IDLE → START → ADDR (8 bits) → ACK1 → DATA (8 bits) → ACK2 → STOP → DONE.
- IDLE lasts 4Q cycles after reset release, with SCL=1 and SDA=1.
- Every state except DONE occupies one slot of 4 quarters (Q0..Q3), each Q cycles long.
- START slot:
  - SCL=1 for all quarters.
  - SDA=1 in Q0–Q1 and 0 in Q2–Q3, so SDA falls while SCL is high.
- Bit slots (ADDR, DATA):
  - SCL=0 in Q0–Q1 and 1 in Q2–Q3.
  - SDA takes the new bit at entry to Q0 and holds it for the whole slot.
  - ADDR shifts {SLAVE_ADDR, 1'b0}; DATA shifts DATA_BYTE. Both go MSB first.
  - A 3-bit counter selects the bit. It runs 7 down to 0, then advances the state.
- ACK slots:
  - SCL waveform is the same as a bit slot; SDA = 'z'.
  - io_i2c_sda is sampled on the last iw_clk edge of Q2.
  - Value exactly 1'b0 is ACK. Anything else (1, z, x) is NACK.
  - ACK1 NACK → STOP, skipping DATA. ACK2 result → STOP either way.
- STOP slot:
  - SCL=0 in Q0–Q1 and 1 in Q2–Q3.
  - SDA=0 in Q0–Q2 and 1 in Q3, so SDA rises while SCL is high.
- DONE: SCL=1, SDA=1 permanently until the next reset. A new transaction starts only via reset.
- Internal nack flag:
  - Set on any NACK; cleared by reset.
  - Not a port; exposed for hierarchical inspection only.

## Timing
- Reset asserted (asynchronous, any time, including mid-byte):
  - io_i2c_scl=1 and io_i2c_sda=1 immediately.
  - State forced to IDLE; counters and nack flag cleared.
  - The aborted transaction is not completed.
- Reset released: IDLE starts at the first iw_clk rising edge with iw_reset low.
- Transaction length with all ACKs = 4Q × (IDLE 1 + START 1 + 9 + 9 + STOP 1) = 84Q cycles. That is 84 cycles at CLK_DIV=4.
- NACK on address: 4Q × (1+1+9+1) = 48Q cycles to DONE.
- SDA never changes while SCL=1, except for the START and STOP edges.
- SCL output is glitch-free, driven directly from a register.

## Test plan
- Reset hold, CLK_DIV=4 (2 ns clock, reset 10 ns):
  - During reset, SCL=1 and SDA=1.
  - After release, SCL/SDA stay 1 for 4 cycles.
  - Then SDA falls with SCL=1 at cycle 6 after release.
- Full write with a bench slave pulling SDA low in both ACK slots:
  - The 8 address bits read at SCL rising edges are 1010_0000 (0xA0).
  - The data bits read are 1010_0101 (0xA5).
  - STOP completes, then DONE idles high; 84 cycles from reset release to DONE.
- No slave (SDA floats 'z' in ACK1):
  - nack flag = 1; no DATA bits emitted.
  - STOP follows ACK1 directly; DONE reached after 48 cycles.
- Slave ACKs the address but NACKs data: all 8 data bits are sent, then STOP; nack=1.
- Async reset asserted mid-DATA byte: SCL and SDA go to 1 within the same time step without waiting for a clock edge. After release, the full sequence restarts from IDLE.
- CLK_DIV=8, full ACK: each SCL phase lasts 4 cycles; total time 168 cycles; same bit pattern.
